// File: rtl/pipeline_broadcast_masked.sv
// Eager fork of one valid/ready stream into N masked valid/ready streams.
// Optional transaction counter port o_txn_count is enabled by PIPELINE_BROADCAST_COUNT_EN.
module pipeline_broadcast_masked #(
  parameter int N     = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             o_valid [N],
  input  logic             o_ready [N],
  input  logic             i_mask  [N],
  output logic             o_busy
`ifdef PIPELINE_BROADCAST_COUNT_EN
  ,
  output logic [CNT_W-1:0] o_txn_count
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    PARTIAL = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   done_q, done_d;
  logic [N-1:0]   pending;
  logic [N-1:0]   fire;
  logic [N-1:0]   settled;
  logic           complete;

  // o_valid never looks at o_ready; the only ready path is o_ready -> i_ready.
  always_comb begin
    pending = '0;
    fire    = '0;
    settled = '0;
    for (int i = 0; i < N; i++) begin
      pending[i] = i_mask[i] & ~done_q[i];
      o_valid[i] = i_valid & pending[i];
      fire[i]    = i_valid & pending[i] & o_ready[i];
      settled[i] = ~pending[i] | fire[i];
    end
    complete = i_valid & (&settled);
  end

  assign i_ready = complete;

  always_comb begin
    done_d  = complete ? '0 : (done_q | fire);
    state_d = (|done_d) ? PARTIAL : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q  <= '0;
      state_q <= IDLE;
    end else begin
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign o_busy = (state_q == PARTIAL);

`ifdef PIPELINE_BROADCAST_COUNT_EN
  logic [CNT_W-1:0] txn_count_q, txn_count_d;

  assign txn_count_d = complete ? txn_count_q + 1'b1 : txn_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= '0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign o_txn_count = txn_count_q;
`else
  // Counter width only matters when the counter is built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
